// File: rtl/ooo_sequencer.sv
// ooo_sequencer: buffers switch values, replays them into the odd-one-out core,
// waits for its result with a timeout and converts it to BCD for the display.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   sw_data              value loaded on a load_btn rising edge
//   load_btn, start_btn  debounced button levels
//   core_reset           one-cycle reset pulse to the core (CLR)
//   core_integers        buffer entry presented to the core (FEED)
//   core_N               entry count presented to the core
//   core_latch           core samples core_integers while high
//   core_ready           core_result valid while high
//   core_result          core output
//   disp_value           BCD {4'h0, hundreds, tens, ones}, 16'hEEEE on timeout
//   count                entries loaded
//   busy, done           CLR/FEED/WAIT/CONV and DONE indicators
//   err_full             sticky, load attempted while full
//   err_timeout          sticky, core never became ready
module ooo_sequencer #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    sw_data,
  input  logic          load_btn,
  input  logic          start_btn,
  output logic          core_reset,
  output logic [7:0]    core_integers,
  output logic [7:0]    core_N,
  output logic          core_latch,
  input  logic          core_ready,
  input  logic [7:0]    core_result,
  output logic [15:0]   disp_value,
  output logic [AW:0]   count,
  output logic          busy,
  output logic          done,
  output logic          err_full,
  output logic          err_timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    FEED,
    WAIT,
    CONV,
    DONE
  } state_t;

  state_t        state;
  logic          load_q;
  logic          start_q;
  logic          load_edge;
  logic          start_edge;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] idx;
  logic [AW:0]   idx_inc;
  logic [TW-1:0] tcnt;
  logic [7:0]    bin;
  logic [10:0]   bcd;
  logic [11:0]   bcd_nxt;
  logic [2:0]    bits;
  logic          full;
  logic          wr_en;
  logic [AW-1:0] wr_addr;

  function automatic logic [3:0] adj4(
    input logic [3:0] d
  );
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Hundreds never exceeds 1 before the final shift of an
  // 8-bit value, so three bits hold it.
  function automatic logic [2:0] adj3(
    input logic [2:0] d
  );
    return (d >= 3'd5) ? d + 3'd3 : d;
  endfunction

  assign load_edge  = load_btn & ~load_q;
  assign start_edge = start_btn & ~start_q;

  assign full    = (count == (AW+1)'(DEPTH));
  assign idx_inc = {1'b0, idx} + (AW+1)'(1);

  assign bcd_nxt = {adj3(bcd[10:8]),
                    adj4(bcd[7:4]),
                    adj4(bcd[3:0]),
                    bin[7]};

  assign core_reset    = (state == CLR);
  assign core_latch    = (state == FEED);
  assign core_integers = core_latch ? mem[idx] : 8'h00;

  // A load in DONE restarts the buffer at entry 0.
  assign wr_en = !reset && load_edge &&
                 ((state == IDLE && !full) ||
                  state == DONE);
  assign wr_addr = (state == DONE) ? '0 : count[AW-1:0];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= sw_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      load_q      <= 1'b1;
      start_q     <= 1'b1;
      count       <= '0;
      idx         <= '0;
      tcnt        <= '0;
      bin         <= '0;
      bcd         <= '0;
      bits        <= '0;
      core_N      <= '0;
      disp_value  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_full    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      load_q  <= load_btn;
      start_q <= start_btn;
      unique case (state)
        IDLE: begin
          if (load_edge) begin
            if (full) begin
              err_full <= 1'b1;
            end else begin
              count <= count + (AW+1)'(1);
            end
          end else if (start_edge && count != '0) begin
            state <= CLR;
            busy  <= 1'b1;
          end
        end
        CLR: begin
          core_N <= 8'(count);
          idx    <= '0;
          state  <= FEED;
        end
        FEED: begin
          if (idx_inc == count) begin
            tcnt  <= '0;
            state <= WAIT;
          end else begin
            idx <= idx + AW'(1);
          end
        end
        WAIT: begin
          if (core_ready) begin
            bin   <= core_result;
            bcd   <= '0;
            bits  <= '0;
            state <= CONV;
          end else if (tcnt == TW'(TIMEOUT)) begin
            err_timeout <= 1'b1;
            disp_value  <= 16'hEEEE;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        CONV: begin
          bcd  <= bcd_nxt[10:0];
          bin  <= {bin[6:0], 1'b0};
          bits <= bits + 3'd1;
          if (bits == 3'd7) begin
            disp_value <= {4'h0, bcd_nxt};
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (load_edge) begin
            count       <= (AW+1)'(1);
            err_full    <= 1'b0;
            err_timeout <= 1'b0;
            done        <= 1'b0;
            state       <= IDLE;
          end else if (start_edge) begin
            done  <= 1'b0;
            busy  <= 1'b1;
            state <= CLR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ooo_sequencer.sv
// tb_ooo_sequencer: directed bench for ooo_sequencer,
// driving buttons and acting as a stub odd-one-out core.
module tb_ooo_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  sw_data;
  logic        load_btn;
  logic        start_btn;
  logic        core_reset;
  logic [7:0]  core_integers;
  logic [7:0]  core_N;
  logic        core_latch;
  logic        core_ready;
  logic [7:0]  core_result;
  logic [15:0] disp_value;
  logic [4:0]  count;
  logic        busy;
  logic        done;
  logic        err_full;
  logic        err_timeout;

  int total = 0;
  int bad   = 0;

  logic [7:0] vals [16];

  ooo_sequencer #(
    .DEPTH(16),
    .AW(4),
    .TIMEOUT(255)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw_data(sw_data),
    .load_btn(load_btn),
    .start_btn(start_btn),
    .core_reset(core_reset),
    .core_integers(core_integers),
    .core_N(core_N),
    .core_latch(core_latch),
    .core_ready(core_ready),
    .core_result(core_result),
    .disp_value(disp_value),
    .count(count),
    .busy(busy),
    .done(done),
    .err_full(err_full),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic load(input logic [7:0] v);
    sw_data  = v;
    load_btn = 1'b1;
    step();
    load_btn = 1'b0;
    step();
  endtask

  task automatic run(
    input int          n,
    input logic [7:0]  res,
    input logic [15:0] exp_disp,
    input int          d,
    input bit          poke
  );
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    chk("clr_rst", 32'(core_reset), 32'd1);
    chk("clr_busy", 32'(busy), 32'd1);
    chk("clr_latch", 32'(core_latch), 32'd0);
    for (int i = 0; i < n; i++) begin
      step();
      chk("feed_latch", 32'(core_latch), 32'd1);
      chk("feed_data", 32'(core_integers),
          32'(vals[i]));
      if (i == 0) begin
        chk("feed_rst", 32'(core_reset), 32'd0);
        chk("core_n", 32'(core_N), 32'(n));
      end
    end
    step();
    chk("wait_latch", 32'(core_latch), 32'd0);
    chk("wait_data", 32'(core_integers), 32'd0);
    if (poke) start_btn = 1'b1;
    for (int i = 1; i < d; i++) begin
      step();
      start_btn = 1'b0;
    end
    core_ready  = 1'b1;
    core_result = res;
    step();
    core_ready = 1'b0;
    repeat (7) step();
    chk("conv_done", 32'(done), 32'd0);
    chk("conv_busy", 32'(busy), 32'd1);
    step();
    chk("done", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("disp", 32'(disp_value), 32'(exp_disp));
    chk("core_n_hold", 32'(core_N), 32'(n));
  endtask

  initial begin
    reset       = 1'b1;
    load_btn    = 1'b1;
    start_btn   = 1'b0;
    core_ready  = 1'b0;
    core_result = 8'h00;
    sw_data     = 8'h99;
    repeat (3) step();
    reset = 1'b0;
    repeat (10) step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_disp", 32'(disp_value), 32'd0);
    chk("rst_n", 32'(core_N), 32'd0);
    chk("rst_latch", 32'(core_latch), 32'd0);
    chk("rst_core_rst", 32'(core_reset), 32'd0);
    chk("rst_data", 32'(core_integers), 32'd0);
    chk("rst_full", 32'(err_full), 32'd0);
    chk("rst_tmo", 32'(err_timeout), 32'd0);
    load_btn = 1'b0;
    step();
    chk("held_count", 32'(count), 32'd0);

    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    chk("empty_rst", 32'(core_reset), 32'd0);
    chk("empty_busy", 32'(busy), 32'd0);
    repeat (3) step();
    chk("empty_latch", 32'(core_latch), 32'd0);
    chk("empty_busy2", 32'(busy), 32'd0);

    vals[0] = 8'd7;
    vals[1] = 8'd3;
    vals[2] = 8'd7;
    for (int i = 0; i < 3; i++) load(vals[i]);
    chk("count3", 32'(count), 32'd3);
    run(3, 8'd3, 16'h0003, 2, 1'b1);
    run(3, 8'd200, 16'h0200, 1, 1'b0);
    run(3, 8'd255, 16'h0255, 3, 1'b0);
    run(3, 8'd0, 16'h0000, 1, 1'b0);

    for (int i = 0; i < 16; i++) vals[i] = 8'(i * 11 + 1);
    load(vals[0]);
    chk("reload_count", 32'(count), 32'd1);
    chk("reload_done", 32'(done), 32'd0);
    for (int i = 1; i < 16; i++) load(vals[i]);
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_full", 32'(err_full), 32'd0);
    load(8'hFF);
    chk("over_count", 32'(count), 32'd16);
    chk("over_full", 32'(err_full), 32'd1);
    run(16, 8'd42, 16'h0042, 2, 1'b0);

    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    repeat (16) step();
    step();
    chk("tmo_wait_latch", 32'(core_latch), 32'd0);
    repeat (255) step();
    chk("tmo_early", 32'(done), 32'd0);
    chk("tmo_early_busy", 32'(busy), 32'd1);
    step();
    chk("tmo_done", 32'(done), 32'd1);
    chk("tmo_flag", 32'(err_timeout), 32'd1);
    chk("tmo_disp", 32'(disp_value), 32'hEEEE);
    load(8'h55);
    chk("clr_count", 32'(count), 32'd1);
    chk("clr_tmo", 32'(err_timeout), 32'd0);
    chk("clr_full", 32'(err_full), 32'd0);
    chk("clr_done", 32'(done), 32'd0);

    load(8'h66);
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    step();
    chk("mid_latch", 32'(core_latch), 32'd1);
    chk("mid_data", 32'(core_integers), 32'h55);
    reset = 1'b1;
    step();
    chk("mrst_latch", 32'(core_latch), 32'd0);
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_disp", 32'(disp_value), 32'hEEEE & 32'h0);
    chk("mrst_n", 32'(core_N), 32'd0);
    reset = 1'b0;
    step();
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_latch", 32'(core_latch), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
